// File: rtl/complex_matrix_accumulator_pkg.sv
// complex_matrix_accumulator_pkg: shared types, FSM states and identity helper for the 2x2 complex accumulator
package complex_matrix_accumulator_pkg;
    localparam int CMA_W = 19;
    typedef logic signed [CMA_W-1:0] comp_t;
    typedef comp_t [0:1][0:1][0:1] mtx_t;
    typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;
    function automatic logic [63:0] ident_comp(input int w, input int frac, input int r, input int c, input int k);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return (r == c && k == 0) ? (64'd1 << frac) & m : 64'd0;
    endfunction
endpackage

// File: rtl/complex_matrix_accumulator_mac.sv
// complex_mac_element: one output component of M x ACC -- four registered products, sum, round half-up, clamp or wrap (SATURATE_EN)
module complex_mac_element #(
    parameter int W    = 19,
    parameter int FRAC = 17,
    parameter int IM   = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                capture_i,
    input  logic [3:0][W-1:0]   a_i,
    input  logic [3:0][W-1:0]   b_i,
    output logic [W-1:0]        res_o,
    output logic                sat_o
);
    localparam int S = 2 * W + 2;
    localparam logic signed [S-1:0] HALF = S'(1) << (FRAC - 1);
    logic signed [2*W-1:0] p_q [4];
    logic signed [S-1:0] sum, rnd;
    // partial products are taken while the FSM sits in MUL1
    always_ff @(posedge clk) begin
        for (int j = 0; j < 4; j++)
            if (reset)
                p_q[j] <= '0;
            else if (capture_i)
                p_q[j] <= (2*W)'($signed(a_i[j])) * (2*W)'($signed(b_i[j]));
    end
`ifdef SATURATE_EN
    localparam logic signed [S-1:0] MAXV = (S'(1) << (W - 1)) - S'(1);
    localparam logic signed [S-1:0] MINV = ~MAXV;
    // imaginary parts add all terms; real parts subtract the im*im terms
    always_comb begin
        sum   = S'(p_q[0]) + S'(p_q[2]) + ((IM != 0) ? S'(p_q[1]) + S'(p_q[3]) : -S'(p_q[1]) - S'(p_q[3]));
        rnd   = (sum + HALF) >>> FRAC;
        sat_o = (rnd > MAXV) || (rnd < MINV);
        res_o = (rnd > MAXV) ? MAXV[W-1:0] : (rnd < MINV) ? MINV[W-1:0] : rnd[W-1:0];
    end
`else
    logic unused_rnd;
    assign unused_rnd = ^rnd;
    // imaginary parts add all terms; real parts subtract the im*im terms; result wraps to W bits
    always_comb begin
        sum   = S'(p_q[0]) + S'(p_q[2]) + ((IM != 0) ? S'(p_q[1]) + S'(p_q[3]) : -S'(p_q[1]) - S'(p_q[3]));
        rnd   = (sum + HALF) >>> FRAC;
        sat_o = 1'b0;
        res_o = rnd[W-1:0];
    end
`endif
endmodule

// File: rtl/complex_matrix_accumulator.sv
// complex_matrix_accumulator: composes a stream of 2x2 complex gates as ACC <= M x ACC (optional SATURATE_EN clamps results)
module complex_matrix_accumulator
    import complex_matrix_accumulator_pkg::*;
#(
    parameter int W     = 19,
    parameter int FRAC  = 17,
    parameter int CNT_W = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic signed [0:1][0:1][0:1][W-1:0]  in_mtx_i,
    input  logic                                in_last_i,
    output logic                                out_valid_o,
    input  logic                                out_ready_i,
    output logic signed [0:1][0:1][0:1][W-1:0]  out_mtx_o,
    output logic [CNT_W-1:0]                    out_count_o,
    output logic                                out_sat_o
);
    state_t                          state_q;
    logic [0:1][0:1][0:1][W-1:0]     acc_q, m_q, id_w, res_w;
    logic [7:0]                      sat_w;
    logic                            last_q, in_ready_q, out_valid_q, sat_q;
    logic [CNT_W-1:0]                cnt_q;

    for (genvar r = 0; r < 2; r++) begin : g_r
        for (genvar c = 0; c < 2; c++) begin : g_c
            for (genvar k = 0; k < 2; k++) begin : g_k
                assign id_w[r][c][k] = W'(ident_comp(W, FRAC, r, c, k));
                complex_mac_element #(.W(W), .FRAC(FRAC), .IM(k)) u_mac (
                    .clk       (clk),
                    .reset     (reset),
                    .capture_i (state_q == MUL1),
                    .a_i       ({m_q[r][1][1], m_q[r][1][0], m_q[r][0][1], m_q[r][0][0]}),
                    .b_i       (k ? {acc_q[1][c][0], acc_q[1][c][1], acc_q[0][c][0], acc_q[0][c][1]}
                                  : {acc_q[1][c][1], acc_q[1][c][0], acc_q[0][c][1], acc_q[0][c][0]}),
                    .res_o     (res_w[r][c][k]),
                    .sat_o     (sat_w[r*4+c*2+k])
                );
            end
        end
    end

    // gate handshake, two-step multiply, then hold the product until the consumer takes it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= id_w;
            m_q         <= '0;
            last_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid_i) begin
                    m_q        <= in_mtx_i;
                    last_q     <= in_last_i;
                    in_ready_q <= 1'b0;
                    state_q    <= MUL1;
                end
                MUL1: state_q <= MUL2;
                MUL2: begin
                    acc_q       <= res_w;
                    cnt_q       <= &cnt_q ? cnt_q : cnt_q + 1'b1;
                    sat_q       <= sat_q | (|sat_w);
                    in_ready_q  <= !last_q;
                    out_valid_q <= last_q;
                    state_q     <= last_q ? DONE : IDLE;
                end
                DONE: if (out_ready_i) begin
                    acc_q       <= id_w;
                    cnt_q       <= '0;
                    sat_q       <= 1'b0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_mtx_o   = acc_q;
    assign out_count_o = cnt_q;
    assign out_sat_o   = sat_q;
endmodule

// File: tb/tb_complex_matrix_accumulator.sv
// tb_complex_matrix_accumulator: randomized and directed checks against a plain-arithmetic complex matrix model
module tb_complex_matrix_accumulator;
    localparam int W = 19, FRAC = 17, CNT_W = 8;
    localparam longint ONE = longint'(1) << FRAC;

    logic clk = 0, reset = 1, in_valid = 0, in_last = 0, out_ready = 0;
    logic in_ready, out_valid, out_sat;
    logic signed [0:1][0:1][0:1][W-1:0] in_mtx = '0, out_mtx;
    logic [CNT_W-1:0] out_count;
    int errors = 0, checks = 0;

    longint macc [2][2][2];
    longint gm [2][2][2];
    int mcnt;
    bit msat;

    complex_matrix_accumulator #(.W(W), .FRAC(FRAC), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_mtx_i(in_mtx), .in_last_i(in_last), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_mtx_o(out_mtx), .out_count_o(out_count), .out_sat_o(out_sat)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                for (int k = 0; k < 2; k++)
                    macc[r][c][k] = (r == c && k == 0) ? ONE : 0;
        mcnt = 0;
        msat = 0;
    endfunction

    function automatic longint fix(longint s);
        longint v;
        v = (s + (longint'(1) << (FRAC - 1))) >>> FRAC;
`ifdef SATURATE_EN
        if (v > (longint'(1) << (W - 1)) - 1) begin v = (longint'(1) << (W - 1)) - 1; msat = 1; end
        if (v < -(longint'(1) << (W - 1))) begin v = -(longint'(1) << (W - 1)); msat = 1; end
`else
        v = v & ((longint'(1) << W) - 1);
        if (v >= (longint'(1) << (W - 1))) v = v - (longint'(1) << W);
`endif
        return v;
    endfunction

    function automatic void model_apply();
        longint t [2][2][2];
        longint re, im;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                re = 0;
                im = 0;
                for (int j = 0; j < 2; j++) begin
                    re += gm[r][j][0] * macc[j][c][0] - gm[r][j][1] * macc[j][c][1];
                    im += gm[r][j][0] * macc[j][c][1] + gm[r][j][1] * macc[j][c][0];
                end
                t[r][c][0] = fix(re);
                t[r][c][1] = fix(im);
            end
        macc = t;
        if (mcnt < (1 << CNT_W) - 1) mcnt++;
    endfunction

    function automatic void gm_clear();
        for (int i = 0; i < 8; i++) gm[i/4][(i/2)%2][i%2] = 0;
    endfunction

    function automatic void gm_random();
        for (int i = 0; i < 8; i++)
            gm[i/4][(i/2)%2][i%2] = longint'($urandom_range(0, (1 << W) - 1)) - (longint'(1) << (W - 1));
    endfunction

    function automatic longint got_comp(int i);
        return longint'($signed(out_mtx[i/4][(i/2)%2][i%2]));
    endfunction

    function automatic longint want_comp(int i);
        return macc[i/4][(i/2)%2][i%2];
    endfunction

    function automatic int first_bad();
        for (int i = 0; i < 8; i++) if (got_comp(i) != want_comp(i)) return i;
        return -1;
    endfunction

    task automatic send(input bit last);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready=%b want 1", in_ready);
        end
        for (int i = 0; i < 8; i++) in_mtx[i/4][(i/2)%2][i%2] = W'(gm[i/4][(i/2)%2][i%2]);
        in_valid = 1;
        in_last = last;
        @(posedge clk); #1;
        in_valid = 0;
        in_last = 0;
        model_apply();
    endtask

    task automatic wait_done();
        int n = 0;
        while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL done_timeout out_valid=%b want 1", out_valid); end
    endtask

    task automatic accept();
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        model_reset();
    endtask

    task automatic test_reset();
        int b;
        reset = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        model_reset();
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        checks++; if (out_count !== 0) begin errors++; $display("FAIL rst_count got=%0d want=0", out_count); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL rst_sat got=%b want=0", out_sat); end
        b = first_bad();
        checks++; if (b != -1) begin errors++; $display("FAIL rst_identity idx=%0d got=%0d want=%0d", b, got_comp(b), want_comp(b)); end
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL idle_outready out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
            end
        end
        out_ready = 0;
    endtask

    task automatic test_hadamard();
        int b;
        longint e;
        gm_clear();
        gm[0][0][0] = 92682; gm[0][1][0] = 92682; gm[1][0][0] = 92682; gm[1][1][0] = -92682;
        send(0);
        send(1);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL had_mul1 out_valid=%b in_ready=%b want 0/0", out_valid, in_ready); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL had_mul2 out_valid=%b want 0", out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL had_latency out_valid=%b want 1", out_valid); end
        for (int i = 0; i < 8; i++) begin
            e = (i == 0 || i == 6) ? 131072 : 0;
            checks++; if (got_comp(i) != e) begin errors++; $display("FAIL had_mtx idx=%0d got=%0d want=%0d", i, got_comp(i), e); end
        end
        checks++; if (out_count !== 2) begin errors++; $display("FAIL had_count got=%0d want=2", out_count); end
        b = first_bad();
        checks++; if (b != -1) begin errors++; $display("FAIL had_model idx=%0d got=%0d want=%0d", b, got_comp(b), want_comp(b)); end
        accept();
    endtask

    task automatic test_pauli();
        longint e;
        gm_clear(); gm[0][1][0] = ONE; gm[1][0][0] = ONE;
        send(0);
        gm_clear(); gm[0][0][0] = ONE; gm[1][1][0] = -ONE;
        send(1);
        wait_done();
        for (int i = 0; i < 8; i++) begin
            e = (i == 2) ? 131072 : (i == 4) ? -131072 : 0;
            checks++; if (got_comp(i) != e) begin errors++; $display("FAIL pauli_mtx idx=%0d got=%0d want=%0d", i, got_comp(i), e); end
        end
        checks++; if (out_count !== 2) begin errors++; $display("FAIL pauli_count got=%0d want=2", out_count); end
        accept();
    endtask

    task automatic test_saturate();
        longint d, e;
        bit s;
`ifdef SATURATE_EN
        d = 262143; s = 1;
`else
        d = -4; s = 0;
`endif
        gm_clear(); gm[0][0][0] = 262143; gm[1][1][0] = 262143;
        send(0);
        send(1);
        wait_done();
        for (int i = 0; i < 8; i++) begin
            e = (i == 0 || i == 6) ? d : 0;
            checks++; if (got_comp(i) != e) begin errors++; $display("FAIL sat_mtx idx=%0d got=%0d want=%0d", i, got_comp(i), e); end
        end
        checks++; if (out_sat !== s) begin errors++; $display("FAIL sat_flag got=%b want=%b", out_sat, s); end
        accept();
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL sat_clear got=%b want=0", out_sat); end
    endtask

    task automatic test_backpressure();
        int b;
        gm_random(); send(0);
        gm_random(); send(1);
        wait_done();
        gm_random();
        for (int i = 0; i < 8; i++) in_mtx[i/4][(i/2)%2][i%2] = W'(gm[i/4][(i/2)%2][i%2]);
        in_valid = 1;
        for (int n = 0; n < 10; n++) begin
            b = first_bad();
            checks++;
            if (b != -1 || out_count !== mcnt || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d bad=%0d count=%0d want=%0d in_ready=%b out_valid=%b", n, b, out_count, mcnt, in_ready, out_valid);
            end
            @(posedge clk); #1;
        end
        in_valid = 0;
        accept();
        b = first_bad();
        checks++; if (b != -1) begin errors++; $display("FAIL bp_identity idx=%0d got=%0d want=%0d", b, got_comp(b), want_comp(b)); end
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
        checks++; if (out_count !== 0) begin errors++; $display("FAIL bp_count_clear got=%0d want=0", out_count); end
    endtask

    task automatic test_reset_mid();
        int b;
        gm_random(); send(0);
        gm_random(); send(0);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        model_reset();
        @(posedge clk); #1;
        b = first_bad();
        checks++; if (b != -1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset bad=%0d in_ready=%b out_valid=%b", b, in_ready, out_valid); end
        gm_random(); send(1);
        wait_done();
        for (int i = 0; i < 8; i++) begin
            checks++; if (got_comp(i) != gm[i/4][(i/2)%2][i%2]) begin errors++; $display("FAIL mid_gate idx=%0d got=%0d want=%0d", i, got_comp(i), gm[i/4][(i/2)%2][i%2]); end
        end
        checks++; if (out_count !== 1) begin errors++; $display("FAIL mid_count got=%0d want=1", out_count); end
        accept();
    endtask

    task automatic test_random();
        int b, len;
        for (int s = 0; s < 8; s++) begin
            len = $urandom_range(1, 4);
            for (int g = 0; g < len; g++) begin gm_random(); send(g == len - 1); end
            wait_done();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #0;
            b = first_bad();
            checks++; if (b != -1) begin errors++; $display("FAIL rnd_mtx seq=%0d idx=%0d got=%0d want=%0d", s, b, got_comp(b), want_comp(b)); end
            checks++; if (out_count !== mcnt || out_sat !== msat) begin errors++; $display("FAIL rnd_flags seq=%0d count=%0d want=%0d sat=%b want=%b", s, out_count, mcnt, out_sat, msat); end
            accept();
        end
    endtask

    task automatic test_count_saturate();
        int b;
        gm_clear(); gm[0][0][0] = ONE; gm[1][1][0] = ONE;
        for (int g = 0; g < 260; g++) send(g == 259);
        wait_done();
        checks++; if (out_count !== (1 << CNT_W) - 1) begin errors++; $display("FAIL cnt_sat got=%0d want=%0d", out_count, (1 << CNT_W) - 1); end
        b = first_bad();
        checks++; if (b != -1) begin errors++; $display("FAIL cnt_mtx idx=%0d got=%0d want=%0d", b, got_comp(b), want_comp(b)); end
        accept();
    endtask

    initial begin
        test_reset();
        test_hadamard();
        test_pauli();
        test_saturate();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_count_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/complex_matrix_accumulator.md
COMPLEX_MATRIX_ACCUMULATOR -- requirements
Module: complex_matrix_accumulator

Interface
REQ-001 Parameter W, default 19: signed fixed-point width of every matrix component.
REQ-002 Parameter FRAC, default 17: fractional bits; legal range is FRAC <= W-2, so 1.0 is representable.
REQ-003 Parameter CNT_W, default 8: width of the gate counter.
REQ-004 clk  input  1  clock.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  in_mtx/in_last valid.
REQ-007 in_ready  output  1  block accepts a matrix this cycle.
REQ-008 in_mtx[0:1][0:1][0:1]  input  W signed  gate matrix, indexed [row][col][0=re,1=im].
REQ-009 in_last  input  1  marks the final gate of a sequence.
REQ-010 out_valid  output  1  composed product is available.
REQ-011 out_ready  input  1  consumer accepts the product.
REQ-012 out_mtx[0:1][0:1][0:1]  output  W signed  composed product, same indexing as in_mtx.
REQ-013 out_count  output  CNT_W  number of gates composed into out_mtx.
REQ-014 out_sat  output  1  sticky flag: saturation occurred during this sequence.

Function
REQ-015 The accumulator ACC SHALL be initialised to the identity: diagonal re = 1<<FRAC, all other components 0.
REQ-016 Each accepted matrix M SHALL update ACC <= M x ACC, so the gate is applied after the existing product.
REQ-017 The FSM SHALL have four states: IDLE, MUL1, MUL2 and DONE.
REQ-018 In IDLE, in_ready=1; an in_valid&&in_ready handshake SHALL capture M and in_last and move to MUL1.
REQ-019 MUL1 SHALL register all 32 real partial products, each 2W bits wide.
REQ-020 MUL2 SHALL sum each component's four terms at width 2W+2 and write ACC.
REQ-021 From MUL2 the FSM SHALL go to DONE if the captured last=1, else to IDLE.
REQ-022 Latency: a handshake in cycle T updates ACC at the end of T+2; in_ready is high again at T+3, or out_valid is high at T+3 when last=1.
REQ-023 Throughput SHALL be one gate per 3 cycles; in_ready=0 in MUL1, MUL2 and DONE.
REQ-024 Rounding SHALL be half-up: add 1<<(FRAC-1), then arithmetic right shift by FRAC.
REQ-025 In DONE: out_valid=1, out_mtx=ACC, and out_count and out_sat are held stable until out_ready.
REQ-026 The DONE handshake SHALL reload ACC with the identity, clear out_count and out_sat, and go to IDLE.
REQ-027 out_count SHALL increment per accepted gate and saturate at 2^CNT_W-1, with no wrap.
REQ-028 out_mtx SHALL equal ACC in every state.
REQ-029 in_valid while in_ready=0 SHALL be ignored; the producer holds its data.

Reset
REQ-030 Reset SHALL force: state IDLE, ACC identity, out_valid=0, in_ready=1 the cycle after release, out_count=0, out_sat=0, partial-product registers 0.
REQ-031 Reset mid-sequence (MUL1, MUL2 or DONE) SHALL discard the in-flight gate and the partial product.

Configuration
REQ-032 With SATURATE_EN defined, each rounded component SHALL clamp to [-2^(W-1), 2^(W-1)-1], and any clamp SHALL set out_sat.
REQ-033 Without SATURATE_EN, the rounded result SHALL be truncated to W bits (two's-complement wrap), and out_sat SHALL be constant 0.

Structure
REQ-034 The shared package SHALL hold the matrix component typedef, the [2][2][2] matrix typedef, the FSM state enum, and the identity constant function of W and FRAC.
REQ-035 One sub-module, complex_mac_element, SHALL compute one output component (four products, sum, round, saturate/wrap); it is instantiated 8 times.

Verification
REQ-036 Identity check (W=19, FRAC=17): reset, then out_ready=1 with no input -> out_valid=0 and in_ready=1 after reset.
REQ-037 Hadamard twice (entries 92682/-92682, last on the second) -> out_mtx diagonal re=131072, all other components 0, out_count=2, out_valid at cycle T2+3.
REQ-038 Pauli X then Z -> out_mtx re: [0][1]=131072, [1][0]=-131072, all else 0; out_count=2.
REQ-039 diag(262143) twice -> with SATURATE_EN: diagonal re=262143 and out_sat=1; without it: diagonal re=-4 and out_sat=0.
REQ-040 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_mtx and out_count are stable and in_ready=0; releasing out_ready gives the identity and in_ready=1 on the next cycle.
REQ-041 Reset asserted in MUL1 of the second gate -> after release, a single gate sent with last=1 returns exactly that gate and out_count=1.
